ps2_rx_frame: RTL

- Receive-only PS/2 serial front end that sits directly upstream of `KeyboardDecoder`.
- Synchronises and deglitches `PS2_CLK`/`PS2_DATA`, then deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop).
- Folds `E0`/`F0` prefix bytes into `is_extend`/`is_break` flags.
- Presents each completed scan-code byte on `key_in` with a one-cycle `valid` strobe, so it is a drop-in source for the decoder's `key_in`/`is_extend`/`is_break`/`valid`/`err` inputs.

---
 rtl/ps2_rx_frame.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: line conditioning, 11-bit frame deserialiser, E0/F0 prefix folding.
// Optional mid-frame stall timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] key_in,
  output logic       is_extend,
  output logic       is_break,
  output logic       valid,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [3:0] FLAST = 4'(FILTER_LEN - 1);

  logic       r_clk_m, r_clk_s, r_dat_m, r_dat_s;
  logic       r_fclk, r_fall;
  logic [3:0] r_fcnt;

  state_t     r_state, w_state;
  logic [7:0] r_shreg, w_shreg;
  logic [2:0] r_bitcnt, w_bitcnt;
  logic       r_par, w_par;
  logic [7:0] r_key, w_key;
  logic       r_ext, w_ext, r_brk, w_brk;
  logic       r_valid, w_valid, r_err, w_err;
  logic       w_timeout, w_frame_ok;

  // Synchronisers plus clock filter; fclk flips only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_m <= 1'b1;
      r_clk_s <= 1'b1;
      r_dat_m <= 1'b1;
      r_dat_s <= 1'b1;
      r_fclk  <= 1'b1;
      r_fcnt  <= 4'd0;
      r_fall  <= 1'b0;
    end else begin
      r_clk_m <= PS2_CLK;
      r_clk_s <= r_clk_m;
      r_dat_m <= PS2_DATA;
      r_dat_s <= r_dat_m;
      r_fall  <= 1'b0;
      if (r_clk_s != r_fclk) begin
        if (r_fcnt == FLAST) begin
          r_fclk <= r_clk_s;
          r_fcnt <= 4'd0;
          r_fall <= r_fclk;
        end else begin
          r_fcnt <= r_fcnt + 4'd1;
        end
      end else begin
        r_fcnt <= 4'd0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tcnt;

  // Stall counter: cleared in IDLE and on every falling edge of the filtered clock.
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE) || r_fall) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && !r_fall && (r_tcnt == TLAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_frame_ok = r_dat_s & (^r_shreg ^ r_par);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state = r_state;
    if (w_timeout) begin
      w_state = ST_IDLE;
    end else if (r_fall) begin
      case (r_state)
        ST_IDLE:   w_state = r_dat_s ? ST_IDLE : ST_DATA;
        ST_DATA:   w_state = (r_bitcnt == 3'd7) ? ST_PARITY : ST_DATA;
        ST_PARITY: w_state = ST_STOP;
        ST_STOP:   w_state = ST_IDLE;
        default:   w_state = ST_IDLE;
      endcase
    end else begin
      w_state = r_state;
    end
  end

  // Output/datapath next values; flags drop the cycle after valid or on any error.
  always_comb begin
    w_shreg  = r_shreg;
    w_bitcnt = r_bitcnt;
    w_par    = r_par;
    w_key    = r_key;
    w_ext    = r_valid ? 1'b0 : r_ext;
    w_brk    = r_valid ? 1'b0 : r_brk;
    w_valid  = 1'b0;
    w_err    = 1'b0;
    if (w_timeout) begin
      w_err = 1'b1;
      w_ext = 1'b0;
      w_brk = 1'b0;
    end else if (r_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (r_dat_s) begin
            w_err = 1'b1;
            w_ext = 1'b0;
            w_brk = 1'b0;
          end else begin
            w_bitcnt = 3'd0;
          end
        end
        ST_DATA: begin
          w_shreg  = {r_dat_s, r_shreg[7:1]};
          w_bitcnt = r_bitcnt + 3'd1;
        end
        ST_PARITY: w_par = r_dat_s;
        ST_STOP: begin
          if (w_frame_ok) begin
            w_key = r_shreg;
            if (r_shreg == 8'hE0) begin
              w_ext = 1'b1;
            end else if (r_shreg == 8'hF0) begin
              w_brk = 1'b1;
            end else begin
              w_valid = 1'b1;
            end
          end else begin
            w_err = 1'b1;
            w_ext = 1'b0;
            w_brk = 1'b0;
          end
        end
        default: w_err = 1'b0;
      endcase
    end else begin
      w_err = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_par    <= 1'b0;
      r_key    <= 8'h00;
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_shreg  <= w_shreg;
      r_bitcnt <= w_bitcnt;
      r_par    <= w_par;
      r_key    <= w_key;
      r_ext    <= w_ext;
      r_brk    <= w_brk;
      r_valid  <= w_valid;
      r_err    <= w_err;
    end
  end

  assign key_in    = r_key;
  assign is_extend = r_ext;
  assign is_break  = r_brk;
  assign valid     = r_valid;
  assign err       = r_err;

endmodule
